// File: rtl/bist_pkg.sv
// Shared BIST definitions: compactor states, MISR polynomial
// and widths common to the TPG and the response compactor.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    COMPACT,
    COMPARE,
    DONE
  } comp_state_e;

  localparam int unsigned BIST_SIG_W    = 16;
  localparam int unsigned BIST_N_CHAINS = 7;

  localparam logic [BIST_SIG_W-1:0] MISR_POLY16 = 16'h1021;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: shift-left Galois MISR
// with parallel injection of the scan-chain outputs.
module misr_core
  import bist_pkg::*;
#(
  parameter int unsigned SIG_W    = BIST_SIG_W,
  parameter int unsigned N_CHAINS = BIST_N_CHAINS,
  parameter logic [SIG_W-1:0] POLY = MISR_POLY16
) (
  input  logic                CK,
  input  logic                COMP_reset,
  input  logic                clr,
  input  logic                en,
  input  logic [N_CHAINS-1:0] d_in,
  output logic [SIG_W-1:0]    sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] fb;

  assign fb = sig_q[SIG_W-1] ? POLY : '0;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ fb
            ^ SIG_W'(d_in);
    end
  end

  always_ff @(posedge CK or posedge COMP_reset) begin
    if (COMP_reset) sig_q <= '0;
    else            sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_resp_compactor.sv
// BIST output-response analyser: skips the priming unload,
// compacts N_PATTERNS unloads into a MISR, checks golden.
module bist_resp_compactor
  import bist_pkg::*;
#(
  parameter int unsigned N_CHAINS   = BIST_N_CHAINS,
  parameter int unsigned SIG_W      = BIST_SIG_W,
  parameter int unsigned CHAIN_LEN  = 33,
  parameter int unsigned N_PATTERNS = 100,
  parameter logic [SIG_W-1:0] POLY  = MISR_POLY16,
  localparam int unsigned SW =
    (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1,
  localparam int unsigned PW =
    $clog2(N_PATTERNS + 1)
) (
  input  logic                CK,
  input  logic                COMP_reset,
  input  logic                bist_en,
  input  logic                scan_en,
  input  logic [N_CHAINS-1:0] so_chain,
  input  logic [SIG_W-1:0]    golden_sig,
  output logic [SIG_W-1:0]    signature,
  output logic [PW-1:0]       pat_cnt,
  output logic                busy,
  output logic                done,
  output logic                pass
);

  comp_state_e state_q, state_d;

  logic [SW-1:0] shift_q, shift_d;
  logic [PW-1:0] pat_q, pat_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          misr_clr;
  logic          misr_en;
  logic          last_shift;
  logic          pat_full;
  logic          sig_eq;
  logic [SIG_W-1:0] sig;

  assign last_shift = (shift_q == SW'(CHAIN_LEN - 1));
  assign pat_full   = (pat_q == PW'(N_PATTERNS));

  // An unknown signature must never report a pass in simulation.
`ifdef SYNTHESIS
  assign sig_eq = (sig == golden_sig);
`else
  assign sig_eq = !$isunknown(sig) && (sig == golden_sig);
`endif

  misr_core #(
    .SIG_W    (SIG_W),
    .N_CHAINS (N_CHAINS),
    .POLY     (POLY)
  ) u_misr (
    .CK         (CK),
    .COMP_reset (COMP_reset),
    .clr        (misr_clr),
    .en         (misr_en),
    .d_in       (so_chain),
    .sig        (sig)
  );

  always_ff @(posedge CK or posedge COMP_reset) begin
    if (COMP_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bist_en) state_d = PRIME;
      end
      PRIME: begin
        if (!bist_en)
          state_d = IDLE;
        else if (scan_en && last_shift)
          state_d = COMPACT;
      end
      COMPACT: begin
        if (!bist_en)     state_d = IDLE;
        else if (pat_full) state_d = COMPARE;
      end
      COMPARE: begin
        state_d = bist_en ? DONE : IDLE;
      end
      DONE: begin
        if (!bist_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      PRIME, COMPACT, COMPARE: busy = 1'b1;
      default:                 busy = 1'b0;
    endcase
  end

  always_comb begin
    shift_d  = shift_q;
    pat_d    = pat_q;
    done_d   = done_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bist_en) begin
          misr_clr = 1'b1;
          shift_d  = '0;
          pat_d    = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
        end
      end
      PRIME: begin
        if (bist_en && scan_en)
          shift_d = last_shift ? '0
                  : shift_q + SW'(1);
      end
      COMPACT: begin
        if (bist_en && scan_en && !pat_full) begin
          misr_en = 1'b1;
          if (last_shift) begin
            shift_d = '0;
            pat_d   = pat_q + PW'(1);
          end else begin
            shift_d = shift_q + SW'(1);
          end
        end
      end
      COMPARE: begin
        if (bist_en) begin
          done_d = 1'b1;
          pass_d = sig_eq;
        end
      end
      default: ;
    endcase
    // Abort keeps signature and pattern count for debug.
    if (busy && !bist_en) begin
      done_d = 1'b0;
      pass_d = 1'b0;
    end
  end

  always_ff @(posedge CK or posedge COMP_reset) begin
    if (COMP_reset) begin
      shift_q <= '0;
      pat_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      pat_q   <= pat_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign signature = sig;
  assign pat_cnt   = pat_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule
